// File: rtl/dlfloat16_pkg.sv
// Shared DLFloat16 constants, pre-round word field widths and the
// normalizer FSM state type.
package dlfloat16_pkg;

    localparam int         DLF_BIAS    = 31;
    localparam logic [5:0] DLF_EXP_MAX = 6'h3F;

    localparam int EXP_W  = 6;
    localparam int FRAC_W = 9;
    localparam int GRS_W  = 4;
    localparam int WORD_W = 1 + EXP_W + FRAC_W + GRS_W;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK,
        HOLD
    } norm_state_e;

endpackage

// File: rtl/dlfloat16_pack.sv
// Field extraction and zero/overflow/underflow classification of a normalized
// mantissa into the 20-bit pre-round word {sign,exp6,frac9,G,R,S1,S2}.
module dlfloat16_pack
    import dlfloat16_pkg::*;
#(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic              sign_i,
    input  logic [EW+1:0]     exp_i,
    input  logic [MW-1:0]     mant_i,
    input  logic              sticky_i,
    output logic [WORD_W-1:0] word_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam logic [EW+1:0] EXP_SAT = (EW+2)'(DLF_EXP_MAX);

    logic [FRAC_W-1:0] frac;
    logic [GRS_W-1:0]  grs;
    logic              exp_neg;

    // NOTE: every output gets a default before the if/else chain so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        frac    = mant_i[MW-3 -: FRAC_W];
        grs     = {mant_i[MW-12], mant_i[MW-13], mant_i[MW-14],
                   (|mant_i[MW-15:0]) | sticky_i};
        exp_neg = exp_i[EW+1];

        word_o = {sign_i, exp_i[EXP_W-1:0], frac, grs};
        zero_o = 1'b0;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;

        // Zero wins over exponent range checks; the exponent is meaningless then.
        if (mant_i == '0) begin
            word_o = {sign_i, {(WORD_W-1){1'b0}}};
            zero_o = 1'b1;
        end else if (!exp_neg && (exp_i >= EXP_SAT)) begin
            word_o = {sign_i, DLF_EXP_MAX, {(FRAC_W+GRS_W){1'b0}}};
            ovf_o  = 1'b1;
        end else if (exp_neg || (exp_i == '0)) begin
            word_o = {sign_i, {(WORD_W-1){1'b0}}};
            unf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/dlfloat16_normalize.sv
// Iterative normalize-and-pack stage: one mantissa bit-shift per cycle, then
// the packed pre-round word is held behind a valid/ready handshake.
module dlfloat16_normalize
    import dlfloat16_pkg::*;
#(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EW-1:0]     in_exp,
    input  logic [MW-1:0]     in_mant,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam logic [EW+1:0] EXP_ONE = (EW+2)'(1);

    norm_state_e       state_q, state_d;
    logic              sign_q, sign_d;
    logic [EW+1:0]     exp_q, exp_d;
    logic [MW-1:0]     mant_q, mant_d;
    logic              sticky_q, sticky_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic              out_zero_q, out_zero_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_unf_q, out_unf_d;

    logic [WORD_W-1:0] pack_word;
    logic              pack_zero;
    logic              pack_ovf;
    logic              pack_unf;

    dlfloat16_pack #(
        .MW (MW),
        .EW (EW)
    ) u_pack (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .mant_i   (mant_q),
        .sticky_i (sticky_q),
        .word_o   (pack_word),
        .zero_o   (pack_zero),
        .ovf_o    (pack_ovf),
        .unf_o    (pack_unf)
    );

    // Gated by rst_n so the input side reads not-ready while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = {{2{in_exp[EW-1]}}, in_exp};
                    mant_d   = in_mant;
                    sticky_d = in_sticky;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    state_d = PACK;
                end else if (mant_q[MW-1]) begin
                    mant_d   = {1'b0, mant_q[MW-1:1]};
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + EXP_ONE;
                end else if (mant_q[MW-2]) begin
                    state_d = PACK;
                end else begin
                    mant_d = {mant_q[MW-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            PACK: begin
                out_word_d  = pack_word;
                out_zero_d  = pack_zero;
                out_ovf_d   = pack_ovf;
                out_unf_d   = pack_unf;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

endmodule
